// File: rtl/decode_queue_if.sv
// Fetch-to-queue and queue-to-dispatch handshake bundle for decode_queue.
// The queue sits on the slave side; fetch/dispatch (or a bench) sits on master.
interface decode_queue_if #(
    parameter int TYPE_BIT = 6
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_inst;
    logic [31:0]         in_pc;

    logic                out_valid;
    logic                out_ready;
    logic [TYPE_BIT-1:0] out_type;
    logic [4:0]          out_rs1;
    logic [4:0]          out_rs2;
    logic [4:0]          out_rd;
    logic [31:0]         out_imm;
    logic [31:0]         out_pc;
    logic                out_is_c;
    logic                out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_type, out_rs1, out_rs2, out_rd,
               out_imm, out_pc, out_is_c, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_type, out_rs1, out_rs2, out_rd,
               out_imm, out_pc, out_is_c, out_illegal
    );
endinterface

// File: rtl/decode_queue.sv
// RV32IC decoder feeding a DEPTH-entry FIFO of decoded tuples; type code 0 marks an
// illegal entry, codes 1..37 enumerate the RV32I instructions in opcode-table order.
module decode_queue #(
    parameter int DEPTH    = 4,
    parameter int TYPE_BIT = 6
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   flush_in,
    decode_queue_if.slave          bus,
    output logic [$clog2(DEPTH):0] count_out
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef logic [TYPE_BIT-1:0] type_t;

    localparam type_t T_LUI   = type_t'(1);
    localparam type_t T_AUIPC = type_t'(2);
    localparam type_t T_JAL   = type_t'(3);
    localparam type_t T_JALR  = type_t'(4);
    localparam type_t T_BEQ   = type_t'(5);
    localparam type_t T_BNE   = type_t'(6);
    localparam type_t T_BLT   = type_t'(7);
    localparam type_t T_BGE   = type_t'(8);
    localparam type_t T_BLTU  = type_t'(9);
    localparam type_t T_BGEU  = type_t'(10);
    localparam type_t T_LB    = type_t'(11);
    localparam type_t T_LH    = type_t'(12);
    localparam type_t T_LW    = type_t'(13);
    localparam type_t T_LBU   = type_t'(14);
    localparam type_t T_LHU   = type_t'(15);
    localparam type_t T_SB    = type_t'(16);
    localparam type_t T_SH    = type_t'(17);
    localparam type_t T_SW    = type_t'(18);
    localparam type_t T_ADDI  = type_t'(19);
    localparam type_t T_SLTI  = type_t'(20);
    localparam type_t T_SLTIU = type_t'(21);
    localparam type_t T_XORI  = type_t'(22);
    localparam type_t T_ORI   = type_t'(23);
    localparam type_t T_ANDI  = type_t'(24);
    localparam type_t T_SLLI  = type_t'(25);
    localparam type_t T_SRLI  = type_t'(26);
    localparam type_t T_SRAI  = type_t'(27);
    localparam type_t T_ADD   = type_t'(28);
    localparam type_t T_SUB   = type_t'(29);
    localparam type_t T_SLL   = type_t'(30);
    localparam type_t T_SLT   = type_t'(31);
    localparam type_t T_SLTU  = type_t'(32);
    localparam type_t T_XOR   = type_t'(33);
    localparam type_t T_SRL   = type_t'(34);
    localparam type_t T_SRA   = type_t'(35);
    localparam type_t T_OR    = type_t'(36);
    localparam type_t T_AND   = type_t'(37);

    typedef struct packed {
        type_t       typ;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        is_c;
        logic        illegal;
    } entry_t;

    function automatic entry_t decode(input logic [31:0] inst);
        entry_t      d;
        logic        bad;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i;
        logic [4:0]  rdp;
        logic [4:0]  rs1p;
        logic [4:0]  crd;
        logic [4:0]  crs2;
        logic signed [31:0] imm_c6;
        logic signed [31:0] imm_cj;
        logic signed [31:0] imm_cb;
        d      = '0;
        bad    = 1'b0;
        f3     = inst[14:12];
        f7     = inst[31:25];
        imm_i  = 32'($signed(inst[31:20]));
        rdp    = {2'b01, inst[4:2]};
        rs1p   = {2'b01, inst[9:7]};
        crd    = inst[11:7];
        crs2   = inst[6:2];
        imm_c6 = 32'($signed({inst[12], inst[6:2]}));
        imm_cj = 32'($signed({inst[12], inst[8], inst[10:9], inst[6], inst[7],
                              inst[2], inst[11], inst[5:3], 1'b0}));
        imm_cb = 32'($signed({inst[12], inst[6:5], inst[2], inst[11:10],
                              inst[4:3], 1'b0}));
        d.is_c = (inst[1:0] != 2'b11);
        if (!d.is_c) begin
            case (inst[6:0])
                7'b0110111, 7'b0010111: begin
                    d.typ = inst[5] ? T_LUI : T_AUIPC;
                    d.rd  = inst[11:7];
                    d.imm = {inst[31:12], 12'b0};
                end
                7'b1101111: begin
                    d.typ = T_JAL;
                    d.rd  = inst[11:7];
                    d.imm = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
                end
                7'b1100111: begin
                    d.typ = T_JALR;
                    d.rd  = inst[11:7];
                    d.rs1 = inst[19:15];
                    d.imm = imm_i;
                    bad   = (f3 != 3'd0);
                end
                7'b1100011: begin
                    d.rs1 = inst[19:15];
                    d.rs2 = inst[24:20];
                    d.imm = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
                    case (f3)
                        3'd0:    d.typ = T_BEQ;
                        3'd1:    d.typ = T_BNE;
                        3'd4:    d.typ = T_BLT;
                        3'd5:    d.typ = T_BGE;
                        3'd6:    d.typ = T_BLTU;
                        3'd7:    d.typ = T_BGEU;
                        default: bad = 1'b1;
                    endcase
                end
                7'b0000011: begin
                    d.rd  = inst[11:7];
                    d.rs1 = inst[19:15];
                    d.imm = imm_i;
                    case (f3)
                        3'd0:    d.typ = T_LB;
                        3'd1:    d.typ = T_LH;
                        3'd2:    d.typ = T_LW;
                        3'd4:    d.typ = T_LBU;
                        3'd5:    d.typ = T_LHU;
                        default: bad = 1'b1;
                    endcase
                end
                7'b0100011: begin
                    d.rs1 = inst[19:15];
                    d.rs2 = inst[24:20];
                    d.imm = 32'($signed({inst[31:25], inst[11:7]}));
                    case (f3)
                        3'd0:    d.typ = T_SB;
                        3'd1:    d.typ = T_SH;
                        3'd2:    d.typ = T_SW;
                        default: bad = 1'b1;
                    endcase
                end
                7'b0010011: begin
                    d.rd  = inst[11:7];
                    d.rs1 = inst[19:15];
                    d.imm = imm_i;
                    case (f3)
                        3'd0: d.typ = T_ADDI;
                        3'd2: d.typ = T_SLTI;
                        3'd3: d.typ = T_SLTIU;
                        3'd4: d.typ = T_XORI;
                        3'd6: d.typ = T_ORI;
                        3'd7: d.typ = T_ANDI;
                        3'd1: begin
                            d.typ = T_SLLI;
                            d.imm = {27'b0, inst[24:20]};
                            bad   = (f7 != 7'b0000000);
                        end
                        default: begin
                            d.imm = {27'b0, inst[24:20]};
                            if (f7 == 7'b0000000)      d.typ = T_SRLI;
                            else if (f7 == 7'b0100000) d.typ = T_SRAI;
                            else                       bad = 1'b1;
                        end
                    endcase
                end
                7'b0110011: begin
                    d.rd  = inst[11:7];
                    d.rs1 = inst[19:15];
                    d.rs2 = inst[24:20];
                    if (f7 == 7'b0000000) begin
                        case (f3)
                            3'd0:    d.typ = T_ADD;
                            3'd1:    d.typ = T_SLL;
                            3'd2:    d.typ = T_SLT;
                            3'd3:    d.typ = T_SLTU;
                            3'd4:    d.typ = T_XOR;
                            3'd5:    d.typ = T_SRL;
                            3'd6:    d.typ = T_OR;
                            default: d.typ = T_AND;
                        endcase
                    end else if (f7 == 7'b0100000 && f3 == 3'd0) begin
                        d.typ = T_SUB;
                    end else if (f7 == 7'b0100000 && f3 == 3'd5) begin
                        d.typ = T_SRA;
                    end else begin
                        bad = 1'b1;
                    end
                end
                default: bad = 1'b1;
            endcase
        end else begin
            case ({inst[1:0], inst[15:13]})
                5'b00_000: begin
                    d.typ = T_ADDI;
                    d.rd  = rdp;
                    d.rs1 = 5'd2;
                    d.imm = {22'b0, inst[10:7], inst[12:11], inst[5], inst[6], 2'b0};
                    bad   = (inst[12:5] == 8'd0);
                end
                5'b00_010, 5'b00_110: begin
                    d.typ = inst[15] ? T_SW : T_LW;
                    d.rs1 = rs1p;
                    if (inst[15]) d.rs2 = rdp;
                    else          d.rd  = rdp;
                    d.imm = {25'b0, inst[5], inst[12:10], inst[6], 2'b0};
                end
                5'b01_000, 5'b01_010: begin
                    d.typ = T_ADDI;
                    d.rd  = crd;
                    d.rs1 = inst[14] ? 5'd0 : crd;
                    d.imm = imm_c6;
                end
                5'b01_001, 5'b01_101: begin
                    d.typ = T_JAL;
                    d.rd  = inst[15] ? 5'd0 : 5'd1;
                    d.imm = imm_cj;
                end
                5'b01_011: begin
                    d.rd = crd;
                    if (crd == 5'd2) begin
                        d.typ = T_ADDI;
                        d.rs1 = 5'd2;
                        d.imm = 32'($signed({inst[12], inst[4:3], inst[5], inst[2], inst[6], 4'b0}));
                    end else begin
                        d.typ = T_LUI;
                        d.imm = 32'($signed({inst[12], inst[6:2], 12'b0}));
                        bad   = ({inst[12], inst[6:2]} == 6'd0);
                    end
                end
                5'b01_100: begin
                    d.rd  = rs1p;
                    d.rs1 = rs1p;
                    case (inst[11:10])
                        2'b00, 2'b01: begin
                            d.typ = inst[10] ? T_SRAI : T_SRLI;
                            d.imm = {27'b0, inst[6:2]};
                            bad   = inst[12];
                        end
                        2'b10: begin
                            d.typ = T_ANDI;
                            d.imm = imm_c6;
                        end
                        default: begin
                            d.rs2 = rdp;
                            bad   = inst[12];
                            case (inst[6:5])
                                2'b00:   d.typ = T_SUB;
                                2'b01:   d.typ = T_XOR;
                                2'b10:   d.typ = T_OR;
                                default: d.typ = T_AND;
                            endcase
                        end
                    endcase
                end
                5'b01_110, 5'b01_111: begin
                    d.typ = inst[13] ? T_BNE : T_BEQ;
                    d.rs1 = rs1p;
                    d.imm = imm_cb;
                end
                5'b10_000: begin
                    d.typ = T_SLLI;
                    d.rd  = crd;
                    d.rs1 = crd;
                    d.imm = {27'b0, inst[6:2]};
                    bad   = inst[12];
                end
                5'b10_010: begin
                    d.typ = T_LW;
                    d.rd  = crd;
                    d.rs1 = 5'd2;
                    d.imm = {24'b0, inst[3:2], inst[12], inst[6:4], 2'b0};
                    bad   = (crd == 5'd0);
                end
                5'b10_100: begin
                    if (crs2 == 5'd0) begin
                        // c.jr / c.jalr; rs1=0 is reserved (c.jr) or c.ebreak, neither decoded
                        d.typ = T_JALR;
                        d.rd  = inst[12] ? 5'd1 : 5'd0;
                        d.rs1 = crd;
                        bad   = (crd == 5'd0);
                    end else begin
                        d.typ = T_ADD;
                        d.rd  = crd;
                        d.rs1 = inst[12] ? crd : 5'd0;
                        d.rs2 = crs2;
                    end
                end
                5'b10_110: begin
                    d.typ = T_SW;
                    d.rs1 = 5'd2;
                    d.rs2 = crs2;
                    d.imm = {24'b0, inst[8:7], inst[12:9], 2'b0};
                end
                default: bad = 1'b1;
            endcase
        end
        if (bad) begin
            d         = '0;
            d.is_c    = (inst[1:0] != 2'b11);
            d.illegal = 1'b1;
        end
        return d;
    endfunction

    entry_t        mem [DEPTH];
    entry_t        dec;
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          push;
    logic          pop;

    always_comb begin
        dec    = decode(bus.in_inst);
        dec.pc = bus.in_pc;
    end

    // Reset is folded into the handshakes so nothing moves during the reset cycle.
    assign bus.in_ready  = !rst_in && rdy_in && !flush_in && (count_q != FULL_CNT);
    assign bus.out_valid = !rst_in && (count_q != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready && rdy_in && !flush_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + (AW+1)'(1);
                    2'b01:   count_q <= count_q - (AW+1)'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= dec;
    end

    // Head fields read as zero whenever there is no valid entry.
    assign head            = bus.out_valid ? mem[rd_ptr] : '0;
    assign bus.out_type    = head.typ;
    assign bus.out_rs1     = head.rs1;
    assign bus.out_rs2     = head.rs2;
    assign bus.out_rd      = head.rd;
    assign bus.out_imm     = head.imm;
    assign bus.out_pc      = head.pc;
    assign bus.out_is_c    = head.is_c;
    assign bus.out_illegal = head.illegal;
    assign count_out       = count_q;
endmodule
